// File: rtl/wts_wave_memory.sv
// Wave-table RAM with a time-multiplexed sample fetch sequencer.
// Each active pulse fetches one sample per voice, then opens one CPU
// access slot so the host can read or write the wave tables without
// contending with the voice fetches.
module wts_wave_memory #(
  parameter int CHANNELS = 5,
  parameter int SAMPLE_W = 8
) (
  input  logic                         clk,
  input  logic                         nreset,
  input  logic                         active,
  input  logic [7*CHANNELS-1:0]        ch_wave_address,
  output logic [SAMPLE_W*CHANNELS-1:0] ch_sample,
  output logic                         sample_valid,
  input  logic                         cpu_wr,
  input  logic                         cpu_rd,
  input  logic [2:0]                   cpu_channel,
  input  logic [6:0]                   cpu_address,
  input  logic [SAMPLE_W-1:0]          cpu_wdata,
  output logic                         cpu_busy,
  output logic [SAMPLE_W-1:0]          cpu_rdata,
  output logic                         cpu_rdata_valid
);

  localparam int DEPTH = CHANNELS * 128;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [2:0] LAST_SLOT = 3'(CHANNELS - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    CPU_SLOT,
    DONE
  } state_t;

  state_t state;
  state_t next_state;
  logic [2:0] slot;
  logic [2:0] next_slot;

  // Wave table storage and its registered read port
  logic [SAMPLE_W-1:0] mem [DEPTH];
  logic [SAMPLE_W-1:0] ram_q;
  logic [AW-1:0]       ram_addr;
  logic                ram_we;

  // Control strobes decoded from the current state
  logic                fetch_now;
  logic                cpu_slot_now;
  logic                sample_valid_next;
  logic [6:0]          fetch_index;

  // Pipeline bookkeeping for the one-cycle RAM read latency
  logic                fetch_load;
  logic [2:0]          fetch_load_idx;
  logic                cpu_finish;
  logic                cpu_finish_rd;

  // Latched CPU request
  logic                req_pending;
  logic                req_write;
  logic                req_ch_ok;
  logic [2:0]          req_channel;
  logic [6:0]          req_address;
  logic [SAMPLE_W-1:0] req_wdata;

  assign cpu_busy = req_pending;

  // Pick the live tone-generator address belonging to the current fetch slot
  always_comb begin
    fetch_index = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (slot == 3'(k)) begin
        fetch_index = ch_wave_address[7*k +: 7];
      end
    end
  end

  // Sequencer state and slot counter
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= IDLE;
      slot  <= '0;
    end else begin
      state <= next_state;
      slot  <= next_slot;
    end
  end

  // Next-state logic plus RAM port steering; DONE spends two cycles so the
  // whole sequence is CHANNELS+3 clocks and sample_valid lands mid-DONE
  always_comb begin
    next_state        = state;
    next_slot         = slot;
    ram_addr          = '0;
    ram_we            = 1'b0;
    fetch_now         = 1'b0;
    cpu_slot_now      = 1'b0;
    sample_valid_next = 1'b0;
    case (state)
      IDLE: begin
        if (active) begin
          next_state = FETCH;
          next_slot  = '0;
        end
      end
      FETCH: begin
        fetch_now = 1'b1;
        ram_addr  = AW'({slot, fetch_index});
        if (slot == LAST_SLOT) begin
          next_state = CPU_SLOT;
          next_slot  = '0;
        end else begin
          next_slot = slot + 3'd1;
        end
      end
      CPU_SLOT: begin
        cpu_slot_now = 1'b1;
        if (req_pending && req_ch_ok) begin
          ram_addr = AW'({req_channel, req_address});
          ram_we   = req_write;
        end
        next_state = DONE;
        next_slot  = '0;
      end
      DONE: begin
        if (slot == 3'd0) begin
          next_slot         = 3'd1;
          sample_valid_next = 1'b1;
        end else begin
          next_state = IDLE;
          next_slot  = '0;
        end
      end
      default: begin
        next_state = IDLE;
        next_slot  = '0;
      end
    endcase
  end

  // Single-port synchronous RAM; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= req_wdata;
    end
    ram_q <= mem[ram_addr];
  end

  // Remember which access was issued so its data can be routed next cycle
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      fetch_load     <= 1'b0;
      fetch_load_idx <= '0;
      cpu_finish     <= 1'b0;
      cpu_finish_rd  <= 1'b0;
      sample_valid   <= 1'b0;
    end else begin
      fetch_load     <= fetch_now;
      fetch_load_idx <= slot;
      cpu_finish     <= cpu_slot_now && req_pending;
      cpu_finish_rd  <= cpu_slot_now && req_pending && !req_write;
      sample_valid   <= sample_valid_next;
    end
  end

  // Route fetched RAM data into the owning channel's sample register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ch_sample <= '0;
    end else if (fetch_load) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (fetch_load_idx == 3'(k)) begin
          ch_sample[SAMPLE_W*k +: SAMPLE_W] <= ram_q;
        end
      end
    end
  end

  // Accept one CPU request at a time; it is retired the cycle after its slot
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      req_pending <= 1'b0;
      req_write   <= 1'b0;
      req_ch_ok   <= 1'b0;
      req_channel <= '0;
      req_address <= '0;
      req_wdata   <= '0;
    end else if (!req_pending) begin
      if (cpu_wr || cpu_rd) begin
        req_pending <= 1'b1;
        req_write   <= cpu_wr;
        req_ch_ok   <= (32'(cpu_channel) < CHANNELS);
        req_channel <= cpu_channel;
        req_address <= cpu_address;
        req_wdata   <= cpu_wdata;
      end
    end else if (cpu_finish) begin
      req_pending <= 1'b0;
    end
  end

  // Deliver CPU read data; tables that do not exist read as zero
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cpu_rdata       <= '0;
      cpu_rdata_valid <= 1'b0;
    end else begin
      cpu_rdata_valid <= cpu_finish_rd;
      if (cpu_finish_rd) begin
        cpu_rdata <= req_ch_ok ? ram_q : '0;
      end
    end
  end

endmodule

// File: tb/tb_wts_wave_memory.sv
// Directed bench for wts_wave_memory with hand-computed expectations.
module tb_wts_wave_memory;

  localparam int C = 5;
  localparam int W = 8;

  logic           clk;
  logic           nreset;
  logic           active;
  logic [7*C-1:0] ch_wave_address;
  logic [W*C-1:0] ch_sample;
  logic           sample_valid;
  logic           cpu_wr;
  logic           cpu_rd;
  logic [2:0]     cpu_channel;
  logic [6:0]     cpu_address;
  logic [W-1:0]   cpu_wdata;
  logic           cpu_busy;
  logic [W-1:0]   cpu_rdata;
  logic           cpu_rdata_valid;

  int errors = 0;
  int checks = 0;

  // Per-edge history of one sequence, index n = edge E0+n
  logic [W*C-1:0] snap [0:10];
  logic [W-1:0]   rd_hist [0:10];
  logic [10:0]    sv_hist;
  logic [10:0]    rv_hist;
  logic [10:0]    busy_hist;

  wts_wave_memory #(.CHANNELS(C), .SAMPLE_W(W)) dut (
    .clk             (clk),
    .nreset          (nreset),
    .active          (active),
    .ch_wave_address (ch_wave_address),
    .ch_sample       (ch_sample),
    .sample_valid    (sample_valid),
    .cpu_wr          (cpu_wr),
    .cpu_rd          (cpu_rd),
    .cpu_channel     (cpu_channel),
    .cpu_address     (cpu_address),
    .cpu_wdata       (cpu_wdata),
    .cpu_busy        (cpu_busy),
    .cpu_rdata       (cpu_rdata),
    .cpu_rdata_valid (cpu_rdata_valid)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [W*C-1:0] packS(input logic [7:0] a0, a1, a2, a3, a4);
    return {a4, a3, a2, a1, a0};
  endfunction

  function automatic logic [7*C-1:0] allAddr(input logic [6:0] a);
    return {a, a, a, a, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-clock CPU strobe
  task automatic applyStimulus(input logic wr, input logic rd, input logic [2:0] ch,
                               input logic [6:0] addr, input logic [7:0] data);
    cpu_wr      = wr;
    cpu_rd      = rd;
    cpu_channel = ch;
    cpu_address = addr;
    cpu_wdata   = data;
    tick();
    cpu_wr = 1'b0;
    cpu_rd = 1'b0;
  endtask

  // Pulse active at E0 and record edges E0..E0+10; optional extra active
  // pulse and cpu_rd strobe sampled at the given edge numbers
  task automatic runPeriod(input int extra_at, input int rd_at);
    active = 1'b1;
    for (int n = 0; n <= 10; n++) begin
      tick();
      snap[n]      = ch_sample;
      rd_hist[n]   = cpu_rdata;
      sv_hist[n]   = sample_valid;
      rv_hist[n]   = cpu_rdata_valid;
      busy_hist[n] = cpu_busy;
      active = (n + 1 == extra_at);
      cpu_rd = (n + 1 == rd_at);
    end
    active = 1'b0;
    cpu_rd = 1'b0;
  endtask

  initial begin
    nreset          = 1'b1;
    active          = 1'b0;
    cpu_wr          = 1'b0;
    cpu_rd          = 1'b0;
    cpu_channel     = '0;
    cpu_address     = '0;
    cpu_wdata       = '0;
    ch_wave_address = allAddr(7'd3);
    #3 nreset = 1'b0;
    tick();
    tick();

    $display("[TB] reset state");
    checkOutput("rst_ch_sample", 64'(ch_sample), 64'h0);
    checkOutput("rst_sample_valid", 64'(sample_valid), 64'h0);
    checkOutput("rst_busy", 64'(cpu_busy), 64'h0);
    checkOutput("rst_rdata", 64'(cpu_rdata), 64'h0);
    checkOutput("rst_rdata_valid", 64'(cpu_rdata_valid), 64'h0);
    nreset = 1'b1;
    tick();

    $display("[TB] write then read-back");
    applyStimulus(1'b1, 1'b0, 3'd2, 7'h15, 8'h7F);
    checkOutput("wr_busy_set", 64'(cpu_busy), 64'h1);
    runPeriod(-1, -1);
    checkOutput("wr_busy_E6", 64'(busy_hist[6]), 64'h1);
    checkOutput("wr_busy_E7", 64'(busy_hist[7]), 64'h0);
    checkOutput("wr_sv_count", 64'($countones(sv_hist)), 64'h1);
    checkOutput("wr_sv_E7", 64'(sv_hist[7]), 64'h1);
    checkOutput("wr_no_rv", 64'($countones(rv_hist)), 64'h0);
    applyStimulus(1'b0, 1'b1, 3'd2, 7'h15, 8'h00);
    runPeriod(-1, -1);
    checkOutput("rd_rv_count", 64'($countones(rv_hist)), 64'h1);
    checkOutput("rd_rv_E7", 64'(rv_hist[7]), 64'h1);
    checkOutput("rd_rdata_E6", 64'(rd_hist[6]), 64'h0);
    checkOutput("rd_rdata_E7", 64'(rd_hist[7]), 64'h7F);
    checkOutput("rd_rdata_hold", 64'(rd_hist[10]), 64'h7F);

    $display("[TB] preload tables");
    for (int k = 0; k < C; k++) begin
      applyStimulus(1'b1, 1'b0, 3'(k), 7'd9, 8'(8'h20 + 2 * k));
      runPeriod(-1, -1);
    end
    ch_wave_address = allAddr(7'd9);
    for (int k = 0; k < C; k++) begin
      applyStimulus(1'b1, 1'b0, 3'(k), 7'd3, 8'(8'h10 + k));
      runPeriod(-1, -1);
    end
    checkOutput("preload_addr9", 64'(snap[10]), 64'(packS(8'h20, 8'h22, 8'h24, 8'h26, 8'h28)));

    $display("[TB] full fetch");
    ch_wave_address = allAddr(7'd3);
    runPeriod(-1, -1);
    for (int k = 0; k < C; k++) begin
      checkOutput($sformatf("fetch_before_ch%0d", k), 64'(snap[1+k][8*k +: 8]), 64'(8'h20 + 2 * k));
      checkOutput($sformatf("fetch_after_ch%0d", k), 64'(snap[2+k][8*k +: 8]), 64'(8'h10 + k));
    end
    checkOutput("fetch_sv_count", 64'($countones(sv_hist)), 64'h1);
    checkOutput("fetch_sv_E7", 64'(sv_hist[7]), 64'h1);

    $display("[TB] collision");
    ch_wave_address = allAddr(7'd9);
    applyStimulus(1'b1, 1'b0, 3'd1, 7'd9, 8'h55);
    runPeriod(-1, -1);
    checkOutput("coll_first", 64'(snap[10]), 64'(packS(8'h20, 8'h22, 8'h24, 8'h26, 8'h28)));
    runPeriod(-1, -1);
    checkOutput("coll_second_E2", 64'(snap[2][15:8]), 64'h22);
    checkOutput("coll_second_E3", 64'(snap[3][15:8]), 64'h55);
    checkOutput("coll_second", 64'(snap[10]), 64'(packS(8'h20, 8'h55, 8'h24, 8'h26, 8'h28)));

    $display("[TB] busy ignore and simultaneous strobes");
    applyStimulus(1'b1, 1'b0, 3'd0, 7'h40, 8'h11);
    applyStimulus(1'b1, 1'b0, 3'd0, 7'h40, 8'h99);
    runPeriod(-1, -1);
    applyStimulus(1'b0, 1'b1, 3'd0, 7'h40, 8'h00);
    runPeriod(-1, -1);
    checkOutput("ignore_readback", 64'(rd_hist[7]), 64'h11);
    applyStimulus(1'b1, 1'b1, 3'd3, 7'h41, 8'h33);
    runPeriod(-1, -1);
    checkOutput("wrrd_no_rv", 64'($countones(rv_hist)), 64'h0);
    applyStimulus(1'b0, 1'b1, 3'd3, 7'h41, 8'h00);
    runPeriod(-1, -1);
    checkOutput("wrrd_readback", 64'(rd_hist[7]), 64'h33);

    $display("[TB] nonexistent channel");
    applyStimulus(1'b1, 1'b0, 3'd7, 7'h15, 8'hAA);
    runPeriod(-1, -1);
    checkOutput("badch_wr_busy_clear", 64'(busy_hist[7]), 64'h0);
    applyStimulus(1'b0, 1'b1, 3'd7, 7'h15, 8'h00);
    runPeriod(-1, -1);
    checkOutput("badch_rv", 64'(rv_hist[7]), 64'h1);
    checkOutput("badch_rdata", 64'(rd_hist[7]), 64'h0);
    applyStimulus(1'b0, 1'b1, 3'd2, 7'h15, 8'h00);
    runPeriod(-1, -1);
    checkOutput("badch_no_alias", 64'(rd_hist[7]), 64'h7F);

    $display("[TB] request at CPU slot edge");
    cpu_channel = 3'd3;
    cpu_address = 7'h41;
    runPeriod(-1, 6);
    checkOutput("late_busy_E5", 64'(busy_hist[5]), 64'h0);
    checkOutput("late_busy_E6", 64'(busy_hist[6]), 64'h1);
    checkOutput("late_busy_hold", 64'(busy_hist[10]), 64'h1);
    checkOutput("late_no_rv", 64'($countones(rv_hist)), 64'h0);
    runPeriod(-1, -1);
    checkOutput("late_rv_E7", 64'(rv_hist[7]), 64'h1);
    checkOutput("late_rdata", 64'(rd_hist[7]), 64'h33);

    $display("[TB] overrun");
    ch_wave_address = allAddr(7'd3);
    runPeriod(3, -1);
    checkOutput("ovr_sv_count", 64'($countones(sv_hist)), 64'h1);
    checkOutput("ovr_sv_E7", 64'(sv_hist[7]), 64'h1);
    checkOutput("ovr_samples", 64'(snap[10]), 64'(packS(8'h10, 8'h11, 8'h12, 8'h13, 8'h14)));
    ch_wave_address = allAddr(7'd9);
    runPeriod(-1, -1);
    checkOutput("ovr_next_sv", 64'($countones(sv_hist)), 64'h1);
    checkOutput("ovr_next_samples", 64'(snap[10]), 64'(packS(8'h20, 8'h55, 8'h24, 8'h26, 8'h28)));

    $display("[TB] reset mid-fetch");
    applyStimulus(1'b1, 1'b0, 3'd0, 7'h40, 8'h77);
    active = 1'b1;
    tick();
    active = 1'b0;
    tick();
    tick();
    nreset = 1'b0;
    #1;
    checkOutput("mrst_ch_sample", 64'(ch_sample), 64'h0);
    checkOutput("mrst_busy", 64'(cpu_busy), 64'h0);
    checkOutput("mrst_rdata", 64'(cpu_rdata), 64'h0);
    checkOutput("mrst_sample_valid", 64'(sample_valid), 64'h0);
    checkOutput("mrst_rdata_valid", 64'(cpu_rdata_valid), 64'h0);
    tick();
    tick();
    nreset = 1'b1;
    tick();
    applyStimulus(1'b0, 1'b1, 3'd0, 7'h40, 8'h00);
    runPeriod(-1, -1);
    checkOutput("mrst_readback", 64'(rd_hist[7]), 64'h11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
